// File: rtl/nn_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : nn_pkg
//  Description : Shared types and defaults for the two-layer FC inference path
//                (sequencer state encoding, chunk geometry, layer-2 select).
//  Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

    // Sequencer state codes; the numeric value is what err_stage reports.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LD_W   = 3'd1,
        S_LD_B   = 3'd2,
        S_RUN    = 3'd3,
        S_L2_W   = 3'd4,
        S_L2_B   = 3'd5,
        S_L2_RUN = 3'd6,
        S_FINISH = 3'd7
    } seq_state_e;

    localparam int N_CHUNKS_DEF = 8;
    localparam int CHUNK_W_DEF  = 64;
    localparam int OUT_W_DEF    = 80;
    localparam int TIMEOUT_DEF  = 65535;

    // Loader select value that addresses the layer-2 parameter set.
    localparam logic [3:0] LAYER2_SEL = 4'(N_CHUNKS_DEF);

    // States that wait on the parameter loader.
    function automatic logic is_load_state(seq_state_e s);
        return (s == S_LD_W) || (s == S_LD_B) || (s == S_L2_W) || (s == S_L2_B);
    endfunction

    // States that wait on the FC engine.
    function automatic logic is_run_state(seq_state_e s);
        return (s == S_RUN) || (s == S_L2_RUN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/layer_sequencer_stage_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : stage_timer
//  Description : 16-bit per-state wait counter. Cleared in the cycle a state
//                is left, so it reads 0 in the first cycle of the next state;
//                expired_o flags that the count has reached TIMEOUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module stage_timer #(
    parameter int TIMEOUT = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic expired_o
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT);

    logic [15:0] cnt_q;

    // Count cycles spent in the current state, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign expired_o = (cnt_q == LIMIT);

endmodule
`default_nettype wire

// File: rtl/layer_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : layer_sequencer
//  Description : Frame scheduler for the two-layer FC path. Steps the shared
//                loader and FC engine through N_CHUNKS layer-1 chunks, builds
//                the layer-1 vector, runs layer 2 and presents the result.
//  Revision    : 1.0 - initial release
// ============================================================================
module layer_sequencer
    import nn_pkg::*;
#(
    parameter int N_CHUNKS = N_CHUNKS_DEF,
    parameter int CHUNK_W  = CHUNK_W_DEF,
    parameter int OUT_W    = OUT_W_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        go,
    output logic                        busy,
    output logic                        ld_start,
    output logic                        ld_bias,
    output logic [3:0]                  ld_sel,
    input  logic                        ld_done,
    output logic                        fc_start,
    output logic                        fc_layer2,
    input  logic                        fc_done,
    input  logic [OUT_W-1:0]            fc_out,
    output logic [N_CHUNKS*CHUNK_W-1:0] l1_vec,
    output logic [OUT_W-1:0]            result,
    output logic                        result_valid,
    output logic                        err,
    output logic [2:0]                  err_stage
);

    localparam logic [3:0] L2_SEL     = 4'(N_CHUNKS);
    localparam logic [3:0] LAST_CHUNK = 4'(N_CHUNKS - 1);

    seq_state_e                  state_q;
    logic [3:0]                  chunk_q;
    logic                        ld_start_q;
    logic                        ld_bias_q;
    logic [3:0]                  ld_sel_q;
    logic                        fc_start_q;
    logic                        fc_layer2_q;
    logic [N_CHUNKS*CHUNK_W-1:0] l1_vec_q;
    logic [OUT_W-1:0]            result_q;
    logic                        result_valid_q;
    logic                        err_q;
    logic [2:0]                  err_stage_q;

    logic w_ld_ok;
    logic w_fc_ok;
    logic w_expired;
    logic w_timeout;
    logic w_timer_clr;

    // Qualify done inputs: only in a state waiting for them and never in the pulse cycle.
    always_comb begin
        w_ld_ok     = ld_done && !ld_start_q && is_load_state(state_q);
        w_fc_ok     = fc_done && !fc_start_q && is_run_state(state_q);
        w_timeout   = w_expired && (is_load_state(state_q) || is_run_state(state_q));
        w_timer_clr = (state_q == S_IDLE) || (state_q == S_FINISH) ||
                      w_ld_ok || w_fc_ok || w_timeout;
    end

    stage_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_stage_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (w_timer_clr),
        .expired_o (w_expired)
    );

    // Frame FSM; all outputs are registered and updated on the transition edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            chunk_q        <= '0;
            ld_start_q     <= 1'b0;
            ld_bias_q      <= 1'b0;
            ld_sel_q       <= '0;
            fc_start_q     <= 1'b0;
            fc_layer2_q    <= 1'b0;
            l1_vec_q       <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
            err_stage_q    <= '0;
        end else begin
            ld_start_q     <= 1'b0;
            fc_start_q     <= 1'b0;
            result_valid_q <= 1'b0;

            if (w_timeout) begin
                // Abandon the frame; partial l1_vec and the old result are kept.
                state_q     <= S_IDLE;
                err_q       <= 1'b1;
                err_stage_q <= state_q;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (go) begin
                            state_q     <= S_LD_W;
                            chunk_q     <= '0;
                            l1_vec_q    <= '0;
                            err_q       <= 1'b0;
                            ld_start_q  <= 1'b1;
                            ld_bias_q   <= 1'b0;
                            ld_sel_q    <= '0;
                            fc_layer2_q <= 1'b0;
                        end
                    end
                    S_LD_W, S_L2_W: begin
                        if (w_ld_ok) begin
                            state_q    <= (state_q == S_LD_W) ? S_LD_B : S_L2_B;
                            ld_start_q <= 1'b1;
                            ld_bias_q  <= 1'b1;
                        end
                    end
                    S_LD_B, S_L2_B: begin
                        if (w_ld_ok) begin
                            state_q    <= (state_q == S_LD_B) ? S_RUN : S_L2_RUN;
                            fc_start_q <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (w_fc_ok) begin
                            l1_vec_q[int'(chunk_q)*CHUNK_W +: CHUNK_W] <= fc_out[CHUNK_W-1:0];
                            ld_start_q <= 1'b1;
                            ld_bias_q  <= 1'b0;
                            if (chunk_q == LAST_CHUNK) begin
                                state_q     <= S_L2_W;
                                ld_sel_q    <= L2_SEL;
                                fc_layer2_q <= 1'b1;
                            end else begin
                                state_q  <= S_LD_W;
                                chunk_q  <= chunk_q + 4'd1;
                                ld_sel_q <= chunk_q + 4'd1;
                            end
                        end
                    end
                    S_L2_RUN: begin
                        if (w_fc_ok) begin
                            state_q        <= S_FINISH;
                            result_q       <= fc_out;
                            result_valid_q <= 1'b1;
                        end
                    end
                    S_FINISH: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign ld_start     = ld_start_q;
    assign ld_bias      = ld_bias_q;
    assign ld_sel       = ld_sel_q;
    assign fc_start     = fc_start_q;
    assign fc_layer2    = fc_layer2_q;
    assign l1_vec       = l1_vec_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign err          = err_q;
    assign err_stage    = err_stage_q;

endmodule
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_layer_sequencer
//  Description : Self-checking bench for layer_sequencer. Behavioural loader
//                and FC responders with a 3-cycle done latency; results are
//                checked through an expected/observed scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_sequencer;
    import nn_pkg::*;

    localparam int NC      = 8;
    localparam int CW      = 64;
    localparam int OW      = 80;
    localparam int TO      = 100;
    localparam int RSP_LAT = 3;
    localparam int N_PULSE = 3 * (NC + 1);
    localparam int FRAME_CYC = 28 + N_PULSE * RSP_LAT;
    localparam logic [OW-1:0] PAT   = {10{8'h01}};
    localparam logic [CW-1:0] PAT64 = {8{8'h01}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic go  = 1'b0;
    logic busy, ld_start, ld_bias, fc_start, fc_layer2, result_valid, err;
    logic [3:0] ld_sel;
    logic [2:0] err_stage;
    logic [NC*CW-1:0] l1_vec;
    logic [OW-1:0] result;
    logic ld_done, fc_done;
    logic [OW-1:0] fc_out;

    logic rsp_ld_done = 1'b0, rsp_fc_done = 1'b0;
    logic inj_ld_done = 1'b0, inj_fc_done = 1'b0;
    logic [OW-1:0] fc_out_r = '0, fc_data = '0;
    logic [OW-1:0] l2_val = '0;
    logic [OW-1:0] last_result = '0;
    int ld_cnt = 0, fc_cnt = 0;
    bit blk_en = 1'b0;
    logic [3:0] blk_sel = 4'd0;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_cnt = 0;
    int pulse_q[$];
    logic [OW-1:0] got_q[$];
    logic [OW-1:0] exp_q[$];

    assign ld_done = rsp_ld_done | inj_ld_done;
    assign fc_done = rsp_fc_done | inj_fc_done;
    assign fc_out  = fc_out_r;

    layer_sequencer #(
        .N_CHUNKS (NC),
        .CHUNK_W  (CW),
        .OUT_W    (OW),
        .TIMEOUT  (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .go           (go),
        .busy         (busy),
        .ld_start     (ld_start),
        .ld_bias      (ld_bias),
        .ld_sel       (ld_sel),
        .ld_done      (ld_done),
        .fc_start     (fc_start),
        .fc_layer2    (fc_layer2),
        .fc_done      (fc_done),
        .fc_out       (fc_out),
        .l1_vec       (l1_vec),
        .result       (result),
        .result_valid (result_valid),
        .err          (err),
        .err_stage    (err_stage)
    );

    always #5 clk = ~clk;

    // Loader responder: done RSP_LAT cycles after the start pulse, optionally withheld.
    always @(negedge clk) begin
        rsp_ld_done = 1'b0;
        if (ld_start) begin
            ld_cnt = (blk_en && ld_bias && ld_sel == blk_sel) ? 0 : RSP_LAT;
        end else if (ld_cnt > 0) begin
            ld_cnt--;
            if (ld_cnt == 0) rsp_ld_done = 1'b1;
        end
    end

    // FC responder: chunk k returns k*0x0101..., layer 2 returns l2_val.
    always @(negedge clk) begin
        rsp_fc_done = 1'b0;
        if (fc_start) begin
            fc_cnt  = RSP_LAT;
            fc_data = fc_layer2 ? l2_val : OW'(ld_sel) * PAT;
        end else if (fc_cnt > 0) begin
            fc_cnt--;
            if (fc_cnt == 0) begin
                rsp_fc_done = 1'b1;
                fc_out_r    = fc_data;
            end
        end
    end

    function automatic int enc_pulse(int kind, logic [3:0] sel, logic l2);
        return kind | (int'(sel) << 4) | (int'(l2) << 8);
    endfunction

    // Expected i-th pulse of a frame: kinds W,B,RUN per stage, layer 2 last.
    function automatic int exp_pulse(int i);
        int stage;
        stage = i / 3;
        return enc_pulse(i % 3, (stage < NC) ? 4'(stage) : LAYER2_SEL, stage == NC);
    endfunction

    function automatic logic [NC*CW-1:0] exp_l1(int n_filled);
        logic [NC*CW-1:0] v;
        v = '0;
        for (int k = 0; k < n_filled; k++) v[k*CW +: CW] = 64'(k) * PAT64;
        return v;
    endfunction

    function automatic int first_bad_pulse();
        for (int i = 0; i < pulse_q.size() && i < N_PULSE; i++)
            if (pulse_q[i] != exp_pulse(i)) return i;
        return -1;
    endfunction

    // Observation log: start pulses, result captures and busy cycles.
    always @(negedge clk) begin
        if (ld_start) pulse_q.push_back(enc_pulse(ld_bias ? 1 : 0, ld_sel, fc_layer2));
        if (fc_start) pulse_q.push_back(enc_pulse(2, ld_sel, fc_layer2));
        if (result_valid) got_q.push_back(result);
        if (busy) busy_cnt++;
    end

    task automatic clear_logs();
        pulse_q.delete();
        got_q.delete();
        exp_q.delete();
        busy_cnt = 0;
    endtask

    task automatic go_pulse();
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int n;
        ok = 1'b0;
        for (n = 0; n < 400 && !ok; n++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, ld_start, ld_bias, ld_sel, fc_start, fc_layer2, result_valid, err, err_stage} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got busy=%b lds=%b bias=%b sel=%0d fcs=%b l2=%b rv=%b err=%b stg=%0d, want all 0",
                     busy, ld_start, ld_bias, ld_sel, fc_start, fc_layer2, result_valid, err, err_stage);
        end
        n_checks++;
        if (l1_vec !== '0 || result !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got l1_vec=%h result=%h, want 0", l1_vec, result);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_nominal();
        bit ok;
        int bad;
        logic [OW-1:0] e, g;
        clear_logs();
        l2_val = 80'h0123_4567_89AB_CDEF_F00D;
        exp_q.push_back(l2_val);
        go_pulse();
        wait_idle(ok);
        last_result = l2_val;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL nominal_done: got busy=%b, want idle within 400 cycles", busy); end
        n_checks++;
        if (pulse_q.size() != N_PULSE) begin
            n_fail++; $display("FAIL nominal_pulse_count: got %0d, want %0d", pulse_q.size(), N_PULSE);
        end
        bad = first_bad_pulse();
        n_checks++;
        if (bad >= 0) begin
            n_fail++; $display("FAIL nominal_pulse_order: index %0d got 0x%0h, want 0x%0h", bad, pulse_q[bad], exp_pulse(bad));
        end
        n_checks++;
        if (l1_vec !== exp_l1(NC)) begin
            n_fail++; $display("FAIL nominal_l1_vec: got %h, want %h", l1_vec, exp_l1(NC));
        end
        n_checks++;
        if (got_q.size() != 1) begin
            n_fail++; $display("FAIL nominal_result_pulses: got %0d, want 1", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL nominal_result: got %h, want %h", g, e); end
        end
        n_checks++;
        if (busy_cnt != FRAME_CYC) begin
            n_fail++; $display("FAIL nominal_frame_len: got %0d, want %0d", busy_cnt, FRAME_CYC);
        end
    endtask

    task automatic test_back_to_back();
        bit ok, seen, gap_idle, restart;
        int n;
        logic [OW-1:0] e, g;
        clear_logs();
        l2_val = 80'hBEEF_0000_1111_2222_3333;
        exp_q.push_back(l2_val);
        exp_q.push_back(l2_val);
        @(posedge clk); #1 go = 1'b1;
        seen = 1'b0;
        for (n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            if (result_valid) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL b2b_first_frame: got no result_valid, want one within 400 cycles"); end
        @(negedge clk); gap_idle = !busy;
        @(negedge clk); restart = busy && ld_start;
        go = 1'b0;
        n_checks++;
        if ({gap_idle, restart} !== 2'b11) begin
            n_fail++; $display("FAIL b2b_restart: got idle_gap=%b restart=%b, want 1 1", gap_idle, restart);
        end
        n_checks++;
        if (got_q.size() != 1) begin
            n_fail++; $display("FAIL b2b_single_frame: got %0d results before restart, want 1", got_q.size());
        end
        wait_idle(ok);
        last_result = l2_val;
        n_checks++;
        if (!ok || got_q.size() != 2) begin
            n_fail++; $display("FAIL b2b_second_frame: got idle=%b results=%0d, want 1 2", ok, got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL b2b_result: got %h, want %h", g, e); end
        end
    endtask

    task automatic test_spurious();
        bit ok, found;
        int n, bad;
        logic [OW-1:0] e, g;
        clear_logs();
        l2_val = 80'h5A5A_0F0F_1234_8765_C3C3;
        exp_q.push_back(l2_val);
        go_pulse();
        // Chunk 0 LD_W pulse cycle now; stray fc_done in its second cycle.
        @(posedge clk); #1 inj_fc_done = 1'b1;
        @(posedge clk); #1 inj_fc_done = 1'b0;
        found = 1'b0;
        for (n = 0; n < 100 && !found; n++) begin
            @(posedge clk); #1;
            if (ld_start && !ld_bias && ld_sel == 4'd1) found = 1'b1;
        end
        if (found) inj_ld_done = 1'b1;
        @(posedge clk); #1 inj_ld_done = 1'b0;
        wait_idle(ok);
        last_result = l2_val;
        n_checks++;
        if (!found || !ok) begin
            n_fail++; $display("FAIL spur_flow: got found=%b idle=%b, want 1 1", found, ok);
        end
        bad = first_bad_pulse();
        n_checks++;
        if (pulse_q.size() != N_PULSE || bad >= 0) begin
            n_fail++; $display("FAIL spur_pulses: got count %0d first_bad %0d, want %0d in order", pulse_q.size(), bad, N_PULSE);
        end
        n_checks++;
        if (busy_cnt != FRAME_CYC) begin
            n_fail++; $display("FAIL spur_frame_len: got %0d, want %0d", busy_cnt, FRAME_CYC);
        end
        n_checks++;
        if (l1_vec !== exp_l1(NC)) begin
            n_fail++; $display("FAIL spur_l1_vec: got %h, want %h", l1_vec, exp_l1(NC));
        end
        n_checks++;
        if (got_q.size() != 1) begin
            n_fail++; $display("FAIL spur_result_pulses: got %0d, want 1", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL spur_result: got %h, want %h", g, e); end
        end
    endtask

    task automatic test_timeout();
        bit found, seen;
        int n, waited;
        clear_logs();
        blk_en  = 1'b1;
        blk_sel = 4'd5;
        go_pulse();
        found = 1'b0;
        for (n = 0; n < 300 && !found; n++) begin
            @(negedge clk);
            if (ld_start && ld_bias && ld_sel == 4'd5) found = 1'b1;
        end
        seen = 1'b0;
        waited = 0;
        for (n = 0; n < 200 && !seen && found; n++) begin
            @(negedge clk);
            waited++;
            if (err) seen = 1'b1;
        end
        blk_en = 1'b0;
        n_checks++;
        if (!found || !seen || waited < TO || waited > TO + 1) begin
            n_fail++; $display("FAIL timeout_latency: got found=%b err=%b after %0d cycles, want err after %0d..%0d",
                               found, seen, waited, TO, TO + 1);
        end
        n_checks++;
        if ({busy, err, err_stage} !== {1'b0, 1'b1, 3'd2}) begin
            n_fail++; $display("FAIL timeout_state: got busy=%b err=%b stage=%0d, want 0 1 2", busy, err, err_stage);
        end
        n_checks++;
        if (result !== last_result || got_q.size() != 0) begin
            n_fail++; $display("FAIL timeout_result: got %h (%0d pulses), want %h (0 pulses)", result, got_q.size(), last_result);
        end
        n_checks++;
        if (l1_vec !== exp_l1(5)) begin
            n_fail++; $display("FAIL timeout_l1_vec: got %h, want %h", l1_vec, exp_l1(5));
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got err=%b, want 1", err); end
    endtask

    task automatic test_err_clear();
        bit ok;
        logic [OW-1:0] e, g;
        clear_logs();
        l2_val = 80'h7777_8888_9999_AAAA_BBBB;
        exp_q.push_back(l2_val);
        go_pulse();
        @(negedge clk);
        n_checks++;
        if ({busy, err} !== 2'b10) begin
            n_fail++; $display("FAIL errclr_on_go: got busy=%b err=%b, want 1 0", busy, err);
        end
        wait_idle(ok);
        last_result = l2_val;
        n_checks++;
        if (!ok || got_q.size() != 1 || err !== 1'b0) begin
            n_fail++; $display("FAIL errclr_frame: got idle=%b results=%0d err=%b, want 1 1 0", ok, got_q.size(), err);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL errclr_result: got %h, want %h", g, e); end
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        int n;
        clear_logs();
        l2_val = 80'h1357_9BDF_2468_ACE0_FFFF;
        go_pulse();
        found = 1'b0;
        for (n = 0; n < 300 && !found; n++) begin
            @(negedge clk);
            if (fc_start && !fc_layer2 && ld_sel == 4'd3) found = 1'b1;
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (!found || {busy, ld_start, ld_bias, ld_sel, fc_start, fc_layer2, result_valid, err, err_stage} !== '0) begin
            n_fail++; $display("FAIL rstmid_ctrl: got found=%b busy=%b sel=%0d bias=%b l2=%b err=%b, want found 1 rest 0",
                               found, busy, ld_sel, ld_bias, fc_layer2, err);
        end
        n_checks++;
        if (l1_vec !== '0 || result !== '0) begin
            n_fail++; $display("FAIL rstmid_data: got l1_vec=%h result=%h, want 0", l1_vec, result);
        end
        repeat (8) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || got_q.size() != 0 || l1_vec !== '0 || result !== '0) begin
            n_fail++; $display("FAIL rstmid_late_done: got busy=%b results=%0d l1_vec=%h result=%h, want 0 0 0 0",
                               busy, got_q.size(), l1_vec, result);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_back_to_back();
        test_spurious();
        test_timeout();
        test_err_clear();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running at 500000ns, want finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/layer_sequencer.md
# layer_sequencer

Central scheduler for the two-layer fully-connected inference path. It replaces the hard-wired start/done daisy chain with one FSM. For each frame it steps a shared parameter loader and a shared FC engine through 8 layer-1 chunks, assembles their outputs into the 512-bit layer-1 vector, runs layer 2, and presents the 80-bit result for UART transmit. It sits between the UART input-collection FSM (which raises `go`) and the TX output FSM (which consumes `result`).

## Interface
Parameters:
- `N_CHUNKS`, 8: layer-1 chunks per frame (`ld_sel` values 0..N_CHUNKS-1).
- `CHUNK_W`, 64: valid low bits of `fc_out` for a layer-1 chunk.
- `OUT_W`, 80: layer-2 result width.
- `TIMEOUT`, 65535: maximum cycles to wait for any done, counted from the start pulse.

Ports:
- `clk`  in  1  system clock (100 MHz domain); one clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `go`  in  1  input buffer holds a complete frame; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `ld_start`  out  1  one-cycle pulse that starts a load.
- `ld_bias`  out  1  0 = weights, 1 = biases; held stable from the pulse until done.
- `ld_sel`  out  4  chunk index 0..N_CHUNKS-1, or N_CHUNKS for layer 2; held stable.
- `ld_done`  in  1  loader finished.
- `fc_start`  out  1  one-cycle pulse that starts the FC engine.
- `fc_layer2`  out  1  0 = layer-1 chunk, 1 = layer 2; held stable.
- `fc_done`  in  1  FC engine finished; `fc_out` valid in the same cycle.
- `fc_out`  in  OUT_W  FC result.
- `l1_vec`  out  N_CHUNKS*CHUNK_W  assembled layer-1 vector; chunk k occupies [k*CHUNK_W +: CHUNK_W].
- `result`  out  OUT_W  layer-2 output; held until the next capture.
- `result_valid`  out  1  one-cycle pulse when `result` updates.
- `err`  out  1  sticky timeout flag; cleared by `rst` or by an accepted `go`.
- `err_stage`  out  3  state code that timed out.

## Operation
- States and codes: IDLE=0, LD_W=1, LD_B=2, RUN=3, L2_W=4, L2_B=5, L2_RUN=6, FINISH=7.
- IDLE + `go` → LD_W. On acceptance: `chunk`=0, `l1_vec` cleared, `err` cleared.
- LD_W → LD_B on `ld_done`.
- LD_B → RUN on `ld_done`.
- RUN on `fc_done`:
  - `l1_vec[chunk*CHUNK_W +: CHUNK_W]` ← `fc_out[CHUNK_W-1:0]`.
  - If `chunk`==N_CHUNKS-1 → L2_W; otherwise `chunk`+1 → LD_W.
- L2_W → L2_B → L2_RUN, same rules as layer 1. In these states `ld_sel`=N_CHUNKS and `fc_layer2`=1.
- L2_RUN on `fc_done`: `result` ← `fc_out` → FINISH.
- FINISH: `result_valid`=1 for exactly this cycle → IDLE.
- Start pulses: every state except IDLE and FINISH asserts its pulse (`ld_start` or `fc_start`) in its first cycle only.
- Done sampling: a done is honoured only from the cycle after the pulse. A done seen in the pulse cycle, or in a state that does not expect it, is ignored.
- Timeout: `wait_cnt` (16 bits) resets on every state entry and increments each cycle.
  - When it reaches TIMEOUT: `err`←1, `err_stage`←current code → IDLE.
  - `l1_vec` is left partially filled and `result` is not updated.
- `go` while busy is ignored. There is no queueing.
- Reset values: state IDLE, `chunk` 0, `wait_cnt` 0, every output 0 (`l1_vec` and `result` all-zero).
- Reset mid-frame aborts at the next edge. Done pulses that arrive after reset are ignored.

## Timing
- Latency from `go` accepted at edge t to `ld_start` high: the cycle after t.
- Latency from any done at edge t to the next start pulse: the cycle after t (one cycle of sequencer overhead per stage).
- Overhead per frame: 3·(N_CHUNKS+1) stages plus 1 FINISH cycle = 28 cycles, in addition to the responders' latency.
- `l1_vec` chunk k is valid from the cycle after its `fc_done`. It must be stable from L2_W onward, since the layer-2 engine reads it.
- From `fc_done` in L2_RUN at edge t: `result` updates at t+1 and `result_valid` is high in that same cycle.
- Fastest next frame: `go` is accepted in the cycle after FINISH.

## Structure
- Shared package `nn_pkg`:
  - state encoding;
  - `N_CHUNKS`, `CHUNK_W`, `OUT_W` defaults;
  - `LAYER2_SEL` = N_CHUNKS.
- One sub-module, `stage_timer`: the 16-bit wait counter with clear-on-entry and a `expired` output.
- Everything else is a single always block (FSM) plus registered outputs.

## Test plan
- Nominal frame, responders with 3-cycle done latency, `fc_out`=chunk index×0x0101…:
  - chunk k lands at `l1_vec[k*64+:64]`;
  - exactly 27 `ld_start`/`fc_start` pulses, in order W,B,RUN;
  - `result`=layer-2 `fc_out` with one `result_valid` pulse;
  - frame length = 28 + 27×3 cycles.
- `go` held high through an entire frame → exactly one frame runs; a second frame starts the cycle after FINISH.
- Withhold `ld_done` in chunk 5 LD_B, TIMEOUT=100 → `err`=1, `err_stage`=2 after 100 cycles, state IDLE, `result` unchanged.
- Assert `rst` during chunk 3 RUN → all outputs 0 the next cycle; a late `fc_done` produces no capture.
- Spurious `fc_done` during LD_W, and `ld_done` in the same cycle as `ld_start` → both ignored; sequence completes normally.
- `err` set, then `go` → `err` clears and the frame completes.
